div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have a single clock and a single reset: one clock; reset is synchronous and active-high.
REQ-002 Port list SHALL be:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- start  in  1  divide request from EX stage (DIV/DIVU in E)
- signed_div  in  1  1 = DIV (two's complement), 0 = DIVU
- cancel  in  1  EX flush/exception; aborts the operation in progress
- opa  in  32  dividend (rs value after forwarding)
- opb  in  32  divisor (rt value after forwarding)
- stall_div  out  1  pipeline stall request while dividing
- done  out  1  one-cycle pulse; result valid
- result  out  64  {hi = remainder, lo = quotient}, for HI/LO write

Function
REQ-003 States SHALL be IDLE, CALC, FIX, DONE, held in a registered state vector.
REQ-004 The block SHALL accept a request when start=1, cancel=0 and state is IDLE or DONE: it latches |opa|, |opb|, the quotient sign (opa[31]^opb[31] when signed) and the remainder sign (opa[31] when signed), clears a 6-bit counter, and enters CALC.
REQ-005 When signed_div=0, the block SHALL use the operands unmodified as magnitudes and leave both signs positive.
REQ-006 CALC SHALL run restoring radix-2 division on a 33-bit partial remainder, producing one quotient bit per cycle, MSB first, for exactly 32 cycles (counter 0..31), then enter FIX.
REQ-007 FIX SHALL negate the quotient if the quotient sign is set and negate the remainder if the remainder sign is set, load result, and enter DONE (1 cycle).
REQ-008 DONE SHALL assert done for exactly one cycle, then go to IDLE, or to CALC if a new request is accepted in that cycle.
REQ-009 stall_div SHALL be combinational: (start & ~cancel & (IDLE|DONE)) | CALC | FIX; it SHALL be 0 in DONE unless a new request is accepted.
REQ-010 Latency SHALL be fixed: start sampled in cycle T -> stall_div high T..T+33 -> done=1 and stall_div=0 in T+34.
REQ-011 start while in CALC or FIX SHALL be ignored.
REQ-012 cancel=1 in any state SHALL force IDLE on the next edge; no done pulse is produced, result is unchanged, and stall_div drops in the same cycle.
REQ-013 result SHALL hold its value from FIX until the next FIX or until reset.
REQ-014 A divisor of zero SHALL yield result = {opa, 32'hFFFF_FFFF} regardless of signed_div; the sign correction of REQ-007 SHALL be bypassed for this case.
REQ-015 Signed 0x8000_0000 / 0xFFFF_FFFF SHALL yield quotient 0x8000_0000 and remainder 0; there is no overflow flag.

Reset
REQ-016 With rst=1 at a clock edge, the block SHALL set state to IDLE, counter to 0, result to 64'h0, done to 0 and the latched signs to 0.
REQ-017 rst SHALL take priority over start and cancel; a reset mid-operation SHALL discard the operation with no done pulse.
REQ-018 stall_div SHALL be 0 in the cycle after reset unless start=1.

Configuration
REQ-019 The macro DIV_ZERO_FAST_EN SHALL select the divide-by-zero path:
- Defined: an accepted request with opb==0 SHALL go directly IDLE/DONE -> DONE, load the REQ-014 result, and pulse done in T+1; stall_div is high only in T.
- Not defined: opb==0 SHALL take the full 34-cycle path of REQ-010, and FIX SHALL still force the REQ-014 result.
REQ-020 All non-zero-divisor behaviour SHALL be identical with and without DIV_ZERO_FAST_EN.

Verification
REQ-021 Unsigned divide: start, signed_div=0, opa=100, opb=7 -> done at T+34, result={32'd2, 32'd14}; stall_div high for exactly 34 cycles.
REQ-022 Signed divide: opa=-7 (0xFFFF_FFF9), opb=2 -> quotient 0xFFFF_FFFD, remainder 0xFFFF_FFFF; second case opa=0x8000_0000, opb=0xFFFF_FFFF -> result={0, 0x8000_0000}.
REQ-023 Cancel mid-operation: cancel=1 at T+10 -> stall_div=0 at T+10, state IDLE at T+11, no done pulse, result keeps its prior value.
REQ-024 Back-to-back: new start asserted in the DONE cycle of operation 1 (opa=9, opb=3) -> done for operation 1 with {0,3}; operation 2 (opa=10, opb=4) done 34 cycles later with {2,2}; start pulses during CALC are ignored.
REQ-025 Divide by zero: opa=0x1234_5678, opb=0 -> result {0x1234_5678, 0xFFFF_FFFF}; done at T+1 with DIV_ZERO_FAST_EN defined, at T+34 without it.
REQ-026 Reset at T+5 of an operation -> state IDLE, result 0, no done pulse; a fresh start at T+7 completes normally.

Source files
------------

// File: rtl/div_seq.sv
// Sequential 32-bit restoring divider (DIV/DIVU) producing {remainder, quotient} for HI/LO.
// Define DIV_ZERO_FAST_EN to complete divide-by-zero in one cycle instead of the full 34.
module div_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        signed_div,
    input  logic        cancel,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        stall_div,
    output logic        done,
    output logic [63:0] result
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] quo_q, quo_d;
    logic [31:0] rem_q, rem_d;
    logic [31:0] dvs_q, dvs_d;
    logic [31:0] opa_q, opa_d;
    logic        qneg_q, qneg_d;
    logic        rneg_q, rneg_d;
    logic        dvz_q, dvz_d;
    logic [63:0] result_q, result_d;

    logic        accept;
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic [32:0] partial;
    logic        fits;

    assign accept  = start && !cancel && (state_q == IDLE || state_q == DONE);
    assign a_neg   = signed_div & opa[31];
    assign b_neg   = signed_div & opb[31];
    assign a_mag   = a_neg ? (~opa + 32'd1) : opa;
    assign b_mag   = b_neg ? (~opb + 32'd1) : opb;
    // Shift the next dividend bit (held in the quotient register MSB) into the remainder.
    assign partial = {rem_q, quo_q[31]};
    assign fits    = (partial >= {1'b0, dvs_q});

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        opa_d    = opa_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        dvz_d    = dvz_q;
        result_d = result_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (accept) begin
                    quo_d   = a_mag;
                    rem_d   = '0;
                    dvs_d   = b_mag;
                    opa_d   = opa;
                    qneg_d  = a_neg ^ b_neg;
                    rneg_d  = a_neg;
                    dvz_d   = (opb == '0);
                    cnt_d   = '0;
                    state_d = CALC;
`ifdef DIV_ZERO_FAST_EN
                    if (opb == '0) begin
                        result_d = {opa, 32'hFFFF_FFFF};
                        state_d  = DONE;
                    end
`endif
                end
            end
            CALC: begin
                rem_d = fits ? (partial[31:0] - dvs_q) : partial[31:0];
                quo_d = {quo_q[30:0], fits};
                cnt_d = cnt_q + 6'd1;
                if (cnt_q == 6'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                // Zero divisor bypasses sign correction so the raw dividend lands in HI.
                if (dvz_q) begin
                    result_d = {opa_q, 32'hFFFF_FFFF};
                end else begin
                    result_d = {rneg_q ? (~rem_q + 32'd1) : rem_q,
                                qneg_q ? (~quo_q + 32'd1) : quo_q};
                end
                state_d = DONE;
            end
            default: state_d = IDLE;
        endcase

        if (cancel) begin
            state_d  = IDLE;
            result_d = result_q;
        end

        stall_div = accept || (!cancel && (state_q == CALC || state_q == FIX));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            opa_q    <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            dvz_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            dvs_q    <= dvs_d;
            opa_q    <= opa_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            dvz_q    <= dvz_d;
            result_q <= result_d;
        end
    end

    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_seq.sv
// Scoreboard bench for div_seq: directed divides queue expected results, a negedge monitor checks them.
module tb_div_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic        signed_div;
    logic        cancel;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        stall_div;
    logic        done;
    logic [63:0] result;

`ifdef DIV_ZERO_FAST_EN
    localparam int ZLAT = 1;
`else
    localparam int ZLAT = 34;
`endif

    typedef struct {
        logic [63:0] res;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          cyc;
    int          n_checks;
    int          n_fail;
    logic [63:0] last_exp;

    div_seq dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .signed_div (signed_div),
        .cancel     (cancel),
        .opa        (opa),
        .opb        (opb),
        .stall_div  (stall_div),
        .done       (done),
        .result     (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued expectation, in value and cycle.
    always @(negedge clk) begin
        if (!rst && done) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 at cycle %0d expected no done", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, " result"}, result, mon_e.res);
                check({mon_e.name, " cycle"}, 64'(cyc), 64'(mon_e.cyc));
            end
        end
    end

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic [63:0] exp_res, input int lat, input string nm,
                         input bit push);
        start      = 1'b1;
        opa        = a;
        opb        = b;
        signed_div = s;
        if (push) begin
            sb.push_back('{res: exp_res, cyc: cyc + lat, name: nm});
            last_exp = exp_res;
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          input logic [63:0] exp_res, input int lat, input string nm);
        int st   = 0;
        bit seen = 1'b0;
        drive(a, b, s, exp_res, lat, nm, 1'b1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (stall_div) st++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            @(posedge clk);
            #1 start = 1'b0;
        end
        check({nm, " done_seen"}, 64'(seen), 64'd1);
        check({nm, " stall_cycles"}, 64'(st), 64'(lat));
        if (seen) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
    endtask

    task automatic wait_drain(input string nm);
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check({nm, " drained"}, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        last_exp   = '0;
        rst        = 1'b1;
        start      = 1'b0;
        signed_div = 1'b0;
        cancel     = 1'b0;
        opa        = '0;
        opb        = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset done", 64'(done), 64'd0);
        check("reset result", result, 64'd0);
        check("reset stall", 64'(stall_div), 64'd0);
        @(posedge clk);
        #1;

        run_op(32'd100,        32'd7,          1'b0, 64'h00000002_0000000E, 34,   "udiv 100/7");
        run_op(32'hFFFF_FFF9,  32'd2,          1'b1, 64'hFFFFFFFF_FFFFFFFD, 34,   "sdiv -7/2");
        run_op(32'h8000_0000,  32'hFFFF_FFFF,  1'b1, 64'h00000000_80000000, 34,   "sdiv min/-1");
        run_op(32'hFFFF_FFF9,  32'd2,          1'b0, 64'h00000001_7FFFFFFC, 34,   "udiv big/2");
        run_op(32'd7,          32'hFFFF_FFFE,  1'b1, 64'h00000001_FFFFFFFD, 34,   "sdiv 7/-2");
        run_op(32'h1234_5678,  32'd0,          1'b0, 64'h12345678_FFFFFFFF, ZLAT, "udiv by zero");
        run_op(32'h8000_0005,  32'd0,          1'b1, 64'h80000005_FFFFFFFF, ZLAT, "sdiv by zero");

        // Cancel at T+10: no done, stall drops immediately, result keeps last value.
        drive(32'd1000, 32'd3, 1'b0, '0, 0, "cancelled", 1'b0);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        cancel = 1'b1;
        @(negedge clk);
        check("cancel stall same cycle", 64'(stall_div), 64'd0);
        @(posedge clk);
        #1 cancel = 1'b0;
        @(negedge clk);
        check("cancel stall after", 64'(stall_div), 64'd0);
        check("cancel done after", 64'(done), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        check("cancel result held", result, last_exp);

        // Back-to-back: op2 issued in op1's DONE cycle, stray start during CALC ignored.
        drive(32'd9, 32'd3, 1'b0, 64'h00000000_00000003, 34, "b2b op1", 1'b1);
        for (int i = 0; i < 34; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        drive(32'd10, 32'd4, 1'b0, 64'h00000002_00000002, 34, "b2b op2", 1'b1);
        @(negedge clk);
        check("b2b stall in done", 64'(stall_div), 64'd1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        drive(32'd100, 32'd1, 1'b0, '0, 0, "stray", 1'b0);
        @(posedge clk);
        #1 start = 1'b0;
        wait_drain("b2b");

        // Reset at T+5 discards the operation; fresh start at T+7 completes normally.
        drive(32'd50, 32'd3, 1'b0, '0, 0, "reset victim", 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1 start = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("midreset result", result, 64'd0);
        check("midreset done", 64'(done), 64'd0);
        check("midreset stall", 64'(stall_div), 64'd0);
        @(posedge clk);
        #1;
        run_op(32'd21, 32'd5, 1'b0, 64'h00000001_00000004, 34, "after reset 21/5");

        repeat (5) @(posedge clk);
        #1;
        wait_drain("final");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
